// File: rtl/multi_channel_system_controller.sv
// rtl/multi_channel_system_controller.sv - SPI command latch, memory read/write sequencer and actuator channel FSMs
module multi_channel_system_controller #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int READ_LAT   = 2,
  parameter int TRIG_PULSE = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       latch_data_sn,
  input  logic [8+ADDR_W+DATA_W-1:0] spi_data,
  input  logic [31:0]                refresh_period,
  input  logic [31:0]                refresh_point,
  input  logic                       trigger_in_sn,
  input  logic [NUM_CH-1:0]          update_done,
  input  logic [DATA_W-1:0]          memory_data_in,
  output logic [DATA_W-1:0]          memory_data_out,
  output logic [ADDR_W-1:0]          memory_address,
  output logic                       memory_enable_n,
  output logic                       memory_write_n,
  output logic                       memory_read_n,
  output logic [DATA_W-1:0]          memory_data,
  output logic                       data_valid_n,
  output logic [NUM_CH-1:0]          system_enable_n,
  output logic                       trigger_out_n,
  output logic [7:0]                 control_state,
  output logic                       busy,
  output logic                       cmd_error
);

  localparam int CMD_W = 8 + ADDR_W + DATA_W;
  localparam int LW    = $clog2(READ_LAT + 1);
  localparam int TW    = $clog2(TRIG_PULSE + 1);

  typedef enum logic [1:0] {L_IDLE, L_CAPT, L_EXEC, L_WAIT} latch_state_t;
  typedef enum logic [2:0] {M_IDLE, M_WR, M_RD, M_LAT, M_VALID} mem_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ARMED, C_RUN, C_DONE} ch_state_t;

  latch_state_t      r_lstate, w_lstate_nxt;
  mem_state_t        r_mstate, w_mstate_nxt;
  ch_state_t         r_ch_state [NUM_CH];
  ch_state_t         w_ch_nxt   [NUM_CH];
  logic [CMD_W-1:0]  r_cmd;
  logic [LW-1:0]     r_lat;
  logic [DATA_W-1:0] r_mem_data;
  logic [NUM_CH-1:0] r_ch_refresh;
  logic [31:0]       r_cnt [NUM_CH];
  logic [TW-1:0]     r_trig;

  logic [7:0]        w_ctrl;
  logic [1:0]        w_op;
  logic [1:0]        w_mode;
  logic              w_mem_idle;
  logic              w_cmd_go;
  logic              w_done_any;
  logic [NUM_CH-1:0] w_sys_en_n;

  assign w_ctrl     = r_cmd[CMD_W-1 -: 8];
  assign w_op       = w_ctrl[1:0];
  assign w_mode     = w_ctrl[3:2];
  assign w_mem_idle = (r_mstate == M_IDLE);
  assign w_cmd_go   = (r_lstate == L_EXEC) && w_mem_idle;

  always_comb begin
    w_lstate_nxt = r_lstate;
    case (r_lstate)
      L_IDLE:  if (!latch_data_sn) w_lstate_nxt = L_CAPT;
      L_CAPT:  w_lstate_nxt = L_EXEC;
      L_EXEC:  if (w_mem_idle) w_lstate_nxt = L_WAIT;
      L_WAIT:  if (latch_data_sn) w_lstate_nxt = L_IDLE;
      default: w_lstate_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lstate <= L_IDLE;
      r_cmd    <= '0;
    end else begin
      r_lstate <= w_lstate_nxt;
      if (r_lstate == L_IDLE && !latch_data_sn) r_cmd <= spi_data;
    end
  end

  always_comb begin
    w_mstate_nxt = r_mstate;
    case (r_mstate)
      M_IDLE: begin
        if (w_cmd_go && w_op == 2'b01) w_mstate_nxt = M_RD;
        if (w_cmd_go && w_op == 2'b10) w_mstate_nxt = M_WR;
      end
      M_WR:    w_mstate_nxt = M_IDLE;
      M_RD:    w_mstate_nxt = M_LAT;
      M_LAT:   if (r_lat == LW'(READ_LAT)) w_mstate_nxt = M_VALID;
      M_VALID: w_mstate_nxt = M_IDLE;
      default: w_mstate_nxt = M_IDLE;
    endcase
  end

  // r_lat counts the cycles after the read strobe; data is taken on the last one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mstate   <= M_IDLE;
      r_lat      <= LW'(1);
      r_mem_data <= '0;
    end else begin
      r_mstate <= w_mstate_nxt;
      r_lat    <= (r_mstate == M_LAT) ? r_lat + LW'(1) : LW'(1);
      if (r_mstate == M_LAT && r_lat == LW'(READ_LAT)) r_mem_data <= memory_data_in;
    end
  end

  always_comb begin
    w_done_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch_nxt[i] = r_ch_state[i];
      if (w_cmd_go && w_ctrl[4+i] && w_mode != 2'b11) begin
        case (w_mode)
          2'b00:   w_ch_nxt[i] = C_IDLE;
          2'b01:   w_ch_nxt[i] = C_RUN;
          default: w_ch_nxt[i] = C_ARMED;
        endcase
      end else begin
        case (r_ch_state[i])
          C_ARMED: if (!trigger_in_sn) w_ch_nxt[i] = C_RUN;
          C_RUN:   if (update_done[i]) w_ch_nxt[i] = C_DONE;
          C_DONE: begin
            if (r_ch_refresh[i]) begin
              if (r_cnt[i] == refresh_point) w_ch_nxt[i] = C_RUN;
            end else if (trigger_in_sn) begin
              w_ch_nxt[i] = C_ARMED;
            end
          end
          default: w_ch_nxt[i] = r_ch_state[i];
        endcase
      end
      if (r_ch_state[i] == C_RUN && w_ch_nxt[i] == C_DONE) w_done_any = 1'b1;
      w_sys_en_n[i] = (r_ch_state[i] != C_RUN);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ch_refresh <= '0;
      r_trig       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch_state[i] <= C_IDLE;
        r_cnt[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch_state[i] <= w_ch_nxt[i];
        if (r_ch_state[i] == C_DONE)
          r_cnt[i] <= (r_cnt[i] >= refresh_period) ? 32'd0 : r_cnt[i] + 32'd1;
        else
          r_cnt[i] <= '0;
        if (w_cmd_go && w_ctrl[4+i] && w_mode == 2'b01) r_ch_refresh[i] <= 1'b1;
        if (w_cmd_go && w_ctrl[4+i] && w_mode == 2'b10) r_ch_refresh[i] <= 1'b0;
      end
      // a completion mid-pulse reloads, stretching the pulse without a gap
      if (w_done_any)       r_trig <= TW'(TRIG_PULSE);
      else if (r_trig != 0) r_trig <= r_trig - TW'(1);
    end
  end

  assign memory_data_out = r_cmd[DATA_W-1:0];
  assign memory_address  = r_cmd[DATA_W +: ADDR_W];
  assign control_state   = w_ctrl;
  assign memory_enable_n = !(r_mstate == M_WR || r_mstate == M_RD);
  assign memory_write_n  = (r_mstate != M_WR);
  assign memory_read_n   = (r_mstate != M_RD);
  assign memory_data     = r_mem_data;
  assign data_valid_n    = (r_mstate != M_VALID);
  assign system_enable_n = w_sys_en_n;
  assign trigger_out_n   = (r_trig == '0);
  assign busy            = (r_lstate == L_CAPT) || (r_lstate == L_EXEC) || !w_mem_idle;
  assign cmd_error       = w_cmd_go && (w_op == 2'b11 || w_mode == 2'b11);

endmodule

// File: tb/tb_multi_channel_system_controller.sv
// tb/tb_multi_channel_system_controller.sv - directed and randomized checks of multi_channel_system_controller
module tb_multi_channel_system_controller;

  logic        clock;
  logic        reset;
  logic        latch_data_sn;
  logic [31:0] spi_data;
  logic [31:0] refresh_period;
  logic [31:0] refresh_point;
  logic        trigger_in_sn;
  logic [3:0]  update_done;
  logic [15:0] memory_data_in;
  logic [15:0] memory_data_out;
  logic [7:0]  memory_address;
  logic        memory_enable_n;
  logic        memory_write_n;
  logic        memory_read_n;
  logic [15:0] memory_data;
  logic        data_valid_n;
  logic [3:0]  system_enable_n;
  logic        trigger_out_n;
  logic [7:0]  control_state;
  logic        busy;
  logic        cmd_error;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          use_force = 0;
  logic [15:0] rec [0:4095];

  multi_channel_system_controller dut (
    .clock(clock), .reset(reset), .latch_data_sn(latch_data_sn), .spi_data(spi_data),
    .refresh_period(refresh_period), .refresh_point(refresh_point), .trigger_in_sn(trigger_in_sn),
    .update_done(update_done), .memory_data_in(memory_data_in), .memory_data_out(memory_data_out),
    .memory_address(memory_address), .memory_enable_n(memory_enable_n), .memory_write_n(memory_write_n),
    .memory_read_n(memory_read_n), .memory_data(memory_data), .data_valid_n(data_valid_n),
    .system_enable_n(system_enable_n), .trigger_out_n(trigger_out_n), .control_state(control_state),
    .busy(busy), .cmd_error(cmd_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every cycle gets a fresh memory word; rec[] remembers what was on the bus in each cycle
  task automatic tick();
    @(posedge clock);
    #2;
    cyc++;
    memory_data_in = use_force ? 16'h1234 : 16'($urandom);
    rec[cyc % 4096] = memory_data_in;
  endtask

  task automatic send_cmd(input logic [7:0] ctrl, input logic [7:0] addr, input logic [15:0] data);
    spi_data      = {ctrl, addr, data};
    latch_data_sn = 1'b0;
    tick();
    latch_data_sn = 1'b1;
    chk("busy_capture", busy, 1'b1);
  endtask

  task automatic run_write(input logic [7:0] addr, input logic [15:0] data);
    int nwr = 0;
    send_cmd(8'h02, addr, data);
    for (int n = 0; n < 8; n++) begin
      tick();
      if (!memory_write_n) begin
        nwr++;
        chk("wr_enable_n", memory_enable_n, 1'b0);
        chk("wr_read_n", memory_read_n, 1'b1);
        chk("wr_address", memory_address, addr);
        chk("wr_data_out", memory_data_out, data);
      end
    end
    chk("wr_strobe_count", nwr, 1);
    chk("wr_control", control_state, 8'h02);
    chk("wr_busy_after", busy, 1'b0);
  endtask

  task automatic run_read(input logic [7:0] addr);
    int  t = 0;
    bit  found = 0;
    send_cmd(8'h01, addr, 16'($urandom));
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (!memory_read_n) begin found = 1; t = cyc; end
    end
    chk("rd_strobe_seen", found, 1'b1);
    if (found) begin
      chk("rd_enable_n", memory_enable_n, 1'b0);
      chk("rd_address", memory_address, addr);
      tick(); chk("rd_dv_t1", data_valid_n, 1'b1);
      tick(); chk("rd_dv_t2", data_valid_n, 1'b1);
      tick(); chk("rd_dv_t3", data_valid_n, 1'b0);
      chk("rd_data", memory_data, rec[(t + 2) % 4096]);
      tick(); chk("rd_dv_t4", data_valid_n, 1'b1);
      chk("rd_data_held", memory_data, rec[(t + 2) % 4096]);
      chk("rd_busy_after", busy, 1'b0);
    end
  endtask

  initial begin
    int  nlow, nerr_p, nstr, t, dv, wr, per, pt;
    bit  found, busy_ok;
    logic [7:0]  a;
    logic [15:0] d;

    reset = 1'b1; latch_data_sn = 1'b1; spi_data = '0; refresh_period = 32'd9;
    refresh_point = 32'd4; trigger_in_sn = 1'b1; update_done = '0; memory_data_in = '0;
    tick(); tick();
    chk("rst_enable_n", memory_enable_n, 1'b1);
    chk("rst_write_n", memory_write_n, 1'b1);
    chk("rst_read_n", memory_read_n, 1'b1);
    chk("rst_dv_n", data_valid_n, 1'b1);
    chk("rst_sys_en_n", system_enable_n, 4'hF);
    chk("rst_trig_out_n", trigger_out_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_error", cmd_error, 1'b0);
    chk("rst_outputs_zero", {control_state, memory_address, memory_data_out, memory_data}, 48'h0);
    reset = 1'b0;
    tick();

    run_write(8'h5A, 16'hBEEF);
    use_force = 1;
    run_read($urandom_range(0, 255));
    use_force = 0;
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom); d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) run_write(a, d); else run_read(a);
    end

    // triggered mode on channels 0 and 1
    send_cmd(8'h38, 8'h00, 16'h0000);
    tick(); tick(); tick();
    chk("trg_armed_idle", system_enable_n, 4'hF);
    chk("trg_control", control_state, 8'h38);
    trigger_in_sn = 1'b0;
    tick();
    chk("trg_run", system_enable_n, 4'b1100);
    update_done = 4'b0011;
    tick();
    update_done = 4'b0000;
    chk("trg_done", system_enable_n, 4'hF);
    nlow = trigger_out_n ? 0 : 1;
    for (int n = 0; n < 6; n++) begin tick(); if (!trigger_out_n) nlow++; end
    chk("trg_pulse_width", nlow, 3);
    chk("trg_no_rearm_while_low", system_enable_n, 4'hF);
    trigger_in_sn = 1'b1;
    tick();
    trigger_in_sn = 1'b0;
    tick();
    chk("trg_rerun", system_enable_n, 4'b1100);
    update_done = 4'b0001;
    tick();
    nlow = trigger_out_n ? 0 : 1;
    update_done = 4'b0010;
    tick();
    if (!trigger_out_n) nlow++;
    update_done = 4'b0000;
    for (int n = 0; n < 6; n++) begin tick(); if (!trigger_out_n) nlow++; end
    chk("trg_pulse_extended", nlow, 4);
    trigger_in_sn = 1'b1;
    send_cmd(8'h30, 8'h00, 16'h0000);
    tick(); tick(); tick();
    trigger_in_sn = 1'b0;
    tick(); tick();
    chk("trg_stopped", system_enable_n, 4'hF);
    trigger_in_sn = 1'b1;

    // periodic refresh on channel 0: a completion reruns after refresh_point+1 cycles in C_DONE
    refresh_period = 32'd9; refresh_point = 32'd4;
    send_cmd(8'h14, 8'h00, 16'h0000);
    found = 0;
    for (int n = 0; n < 6 && !found; n++) begin tick(); if (!system_enable_n[0]) found = 1; end
    chk("ref_first_run", system_enable_n, 4'b1110);
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin per = 9; pt = 4; end
      else begin per = $urandom_range(2, 10); pt = $urandom_range(0, per); end
      refresh_period = per; refresh_point = pt;
      update_done = 4'b0001;
      tick();
      update_done = 4'b0000;
      for (int j = 0; j < pt + 3; j++) begin
        chk($sformatf("ref_it%0d_j%0d", it, j), system_enable_n, {3'b111, (j <= pt)});
        tick();
      end
    end
    refresh_period = 32'd5; refresh_point = 32'd7;
    update_done = 4'b0001;
    tick();
    update_done = 4'b0000;
    nlow = 0;
    for (int n = 0; n < 24; n++) begin tick(); if (!system_enable_n[0]) nlow++; end
    chk("ref_point_beyond_period", nlow, 0);
    send_cmd(8'h10, 8'h00, 16'h0000);
    tick(); tick(); tick();
    chk("ref_stopped", system_enable_n, 4'hF);

    // reserved op, then reserved mode
    for (int r = 0; r < 2; r++) begin
      send_cmd(r == 0 ? 8'h03 : 8'h4C, 8'h11, 16'h2222);
      nerr_p = 0; nstr = 0;
      for (int n = 0; n < 6; n++) begin
        tick();
        if (cmd_error) nerr_p++;
        if (!memory_enable_n) nstr++;
      end
      chk($sformatf("rsv%0d_cmd_error_pulse", r), nerr_p, 1);
      chk($sformatf("rsv%0d_no_strobe", r), nstr, 0);
      chk($sformatf("rsv%0d_channels", r), system_enable_n, 4'hF);
    end

    // command strobed while a read is still in flight
    a = 8'($urandom);
    send_cmd(8'h01, a, 16'h0000);
    found = 0; t = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (!memory_read_n) begin found = 1; t = cyc; end
    end
    chk("ovl_read_seen", found, 1'b1);
    dv = 0; wr = 0; busy_ok = 1;
    spi_data = {8'h02, 8'hC3, 16'h5AA5};
    for (int n = 0; n < 12; n++) begin
      if (cyc <= t + 3 && !busy) busy_ok = 0;
      if (!data_valid_n) begin
        dv = cyc;
        chk("ovl_read_data", memory_data, rec[(t + 2) % 4096]);
      end
      if (!memory_write_n) begin
        wr = cyc;
        chk("ovl_write_addr", memory_address, 8'hC3);
      end
      if (cyc == t + 1) latch_data_sn = 1'b0;
      if (cyc == t + 2) latch_data_sn = 1'b1;
      tick();
    end
    chk("ovl_busy_through_read", busy_ok, 1'b1);
    chk("ovl_dv_cycle", dv - t, 3);
    chk("ovl_write_after_read", (wr > dv), 1'b1);

    // asynchronous reset in the middle of a read strobe
    send_cmd(8'h01, 8'h77, 16'h0000);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (!memory_read_n) found = 1;
    end
    chk("arst_read_seen", found, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("arst_read_n", memory_read_n, 1'b1);
    chk("arst_enable_n", memory_enable_n, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_control", control_state, 8'h00);
    tick();
    reset = 1'b0;
    nstr = 0;
    for (int n = 0; n < 6; n++) begin tick(); if (!memory_enable_n || busy) nstr++; end
    chk("arst_nothing_pending", nstr, 0);
    chk("arst_dv_n", data_valid_n, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
